paddle_motion_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 48 ++++
 rtl/paddle_motion_ctrl.sv | 174 +++++++++++++++++
 tb/tb_paddle_motion_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the Pong game datapath.
//   COORD_W            : width of a screen coordinate
//   SCREEN_W/SCREEN_H  : visible resolution
//   dir_e              : paddle direction (UP decreases position)
//   motion_state_e     : paddle motion FSM states
//   cmd_e              : resolved button command
package game_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAMP   = 2'd1,
        ST_CRUISE = 2'd2
    } motion_state_e;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_UP   = 2'd1,
        CMD_DOWN = 2'd2
    } cmd_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability-counter debouncer.
//   clk     : system clock
//   reset   : asynchronous, active-high reset
//   btn_raw : raw asynchronous button level
//   btn_db  : debounced level; follows btn_raw after it has been stable
//             for DEBOUNCE_CYCLES cycles past the synchronizer
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync_0;
    logic             sync_1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
        end else begin
            sync_0 <= btn_raw;
            sync_1 <= sync_0;
        end
    end

    // Any return to the accepted level restarts the count, so a glitch
    // shorter than DEBOUNCE_CYCLES never reaches btn_db.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            btn_db <= 1'b0;
        end else if (sync_1 == btn_db) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt    <= '0;
            btn_db <= sync_1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/paddle_motion_ctrl.sv
// Frame-synchronous paddle motion scheduler.
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   btn        : raw buttons, [0]=up (decrease pos), [1]=down (increase pos)
//   frame_tick : one-cycle pulse per video frame
//   max_pos    : highest legal bar position
//   bar_pos    : registered bar position
//   speed      : current step size in pixels/frame, 0 when idle
//   moving     : FSM is not idle
//   at_limit   : bar_pos is 0 or max_pos (registered with bar_pos)
module paddle_motion_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned V_MIN           = 1,
    parameter int unsigned V_MAX           = 4,
    parameter int unsigned ACCEL_FRAMES    = 8,
    parameter int unsigned RESET_POS       = 240
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         btn,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] max_pos,
    output logic [COORD_W-1:0] bar_pos,
    output logic [3:0]         speed,
    output logic               moving,
    output logic               at_limit
);

    localparam int unsigned FC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    // A fresh start lands directly in CRUISE when there is nothing to ramp.
    localparam motion_state_e START_STATE = (V_MIN == V_MAX) ? ST_CRUISE : ST_RAMP;

    logic [1:0]         db;
    cmd_e               cmd;
    dir_e               cmd_dir;

    motion_state_e      state, state_n;
    dir_e               dir, dir_n;
    logic [3:0]         speed_n;
    logic [FC_W-1:0]    frame_cnt, frame_cnt_n;
    logic [3:0]         step;
    logic               move;
    logic               restart;

    logic [COORD_W-1:0] p;
    logic [COORD_W:0]   sum;
    logic [COORD_W-1:0] pos_n;
    logic               at_limit_n;

    for (genvar i = 0; i < 2; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn[i]),
            .btn_db (db[i])
        );
    end

    always_comb begin
        cmd = CMD_NONE;
        if (db[0] && !db[1]) begin
            cmd = CMD_UP;
        end else if (db[1] && !db[0]) begin
            cmd = CMD_DOWN;
        end
        cmd_dir = (cmd == CMD_UP) ? DIR_UP : DIR_DOWN;
    end

    // Next-state: a new press and a reversal share the restart path.
    always_comb begin
        state_n     = state;
        dir_n       = dir;
        speed_n     = speed;
        frame_cnt_n = frame_cnt;
        step        = '0;
        move        = 1'b0;
        restart     = 1'b0;

        if (frame_tick) begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd != CMD_NONE) begin
                        restart = 1'b1;
                    end
                end
                ST_RAMP: begin
                    if (cmd == CMD_NONE) begin
                        state_n = ST_IDLE;
                        speed_n = '0;
                    end else if (cmd_dir != dir) begin
                        restart = 1'b1;
                    end else begin
                        move = 1'b1;
                        if (frame_cnt == FC_W'(ACCEL_FRAMES - 1)) begin
                            speed_n     = speed + 4'd1;
                            frame_cnt_n = '0;
                            if (speed_n == 4'(V_MAX)) begin
                                state_n = ST_CRUISE;
                            end
                        end else begin
                            frame_cnt_n = frame_cnt + 1'b1;
                        end
                        // The step taken uses the speed after this tick's increment.
                        step = speed_n;
                    end
                end
                ST_CRUISE: begin
                    if (cmd == CMD_NONE) begin
                        state_n = ST_IDLE;
                        speed_n = '0;
                    end else if (cmd_dir != dir) begin
                        restart = 1'b1;
                    end else begin
                        move = 1'b1;
                        step = 4'(V_MAX);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    speed_n = '0;
                end
            endcase

            if (restart) begin
                state_n     = START_STATE;
                dir_n       = cmd_dir;
                speed_n     = 4'(V_MIN);
                frame_cnt_n = '0;
                step        = 4'(V_MIN);
                move        = 1'b1;
            end
        end
    end

    // Position is first pulled inside max_pos, then stepped and clamped.
    always_comb begin
        p     = (bar_pos > max_pos) ? max_pos : bar_pos;
        sum   = {1'b0, p} + (COORD_W + 1)'(step);
        pos_n = p;
        if (move) begin
            if (dir_n == DIR_UP) begin
                pos_n = (p < COORD_W'(step)) ? '0 : p - COORD_W'(step);
            end else begin
                pos_n = (sum > {1'b0, max_pos}) ? max_pos : sum[COORD_W-1:0];
            end
        end
        at_limit_n = (pos_n == '0) || (pos_n == max_pos);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            dir       <= DIR_UP;
            speed     <= '0;
            frame_cnt <= '0;
            bar_pos   <= COORD_W'(RESET_POS);
            at_limit  <= 1'b0;
        end else if (frame_tick) begin
            state     <= state_n;
            dir       <= dir_n;
            speed     <= speed_n;
            frame_cnt <= frame_cnt_n;
            bar_pos   <= pos_n;
            at_limit  <= at_limit_n;
        end
    end

    assign moving = (state != ST_IDLE);

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
module tb_paddle_motion_ctrl;

    localparam int DB_CYC = 4;
    localparam int VMIN   = 1;
    localparam int VMAX   = 3;
    localparam int AFR    = 2;
    localparam int RPOS   = 240;

    localparam int C_NONE = 0;
    localparam int C_UP   = 1;
    localparam int C_DOWN = 2;

    typedef struct {
        int pos;
        int spd;
        int mov;
        int at;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn = 2'b00;
    logic       frame_tick = 1'b0;
    logic [9:0] max_pos = 10'd479;
    logic [9:0] bar_pos;
    logic [3:0] speed;
    logic       moving;
    logic       at_limit;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb_q[$];

    // reference model state (0 idle, 1 ramp, 2 cruise; dir uses C_UP/C_DOWN)
    int m_state, m_dir, m_speed, m_fc, m_pos, m_at;

    paddle_motion_ctrl #(
        .DEBOUNCE_CYCLES(DB_CYC),
        .V_MIN(VMIN),
        .V_MAX(VMAX),
        .ACCEL_FRAMES(AFR),
        .RESET_POS(RPOS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .frame_tick(frame_tick),
        .max_pos   (max_pos),
        .bar_pos   (bar_pos),
        .speed     (speed),
        .moving    (moving),
        .at_limit  (at_limit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_dir = C_UP; m_speed = 0; m_fc = 0; m_pos = RPOS; m_at = 0;
    endtask

    task automatic model_tick(input int cmd);
        int step;
        int p;
        bit rst_motion;
        step = 0;
        rst_motion = 0;
        p = (m_pos > int'(max_pos)) ? int'(max_pos) : m_pos;
        if (cmd == C_NONE) begin
            m_state = 0;
            m_speed = 0;
        end else if (m_state == 0 || cmd != m_dir) begin
            rst_motion = 1;
        end else if (m_state == 2) begin
            step = VMAX;
        end else begin
            if (m_fc == AFR - 1) begin
                m_fc = 0;
                m_speed = m_speed + 1;
                if (m_speed == VMAX) m_state = 2;
            end else begin
                m_fc = m_fc + 1;
            end
            step = m_speed;
        end
        if (rst_motion) begin
            m_dir = cmd; m_speed = VMIN; m_fc = 0; step = VMIN;
            m_state = (VMIN == VMAX) ? 2 : 1;
        end
        if (step > 0) begin
            if (m_dir == C_UP) p = (p < step) ? 0 : p - step;
            else               p = (p + step > int'(max_pos)) ? int'(max_pos) : p + step;
        end
        m_pos = p;
        m_at  = (p == 0 || p == int'(max_pos)) ? 1 : 0;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_pos"},    int'(bar_pos), e.pos);
            check({tag, "_speed"},  int'(speed),   e.spd);
            check({tag, "_moving"}, int'(moving),  e.mov);
            check({tag, "_limit"},  int'(at_limit), e.at);
        end
    endtask

    // Called at a negedge: one frame_tick cycle, then compare after the edge.
    task automatic do_tick(input string tag, input int cmd, input bit use_tbl, input exp_t tbl);
        exp_t e;
        model_tick(cmd);
        if (use_tbl) e = tbl;
        else e = '{pos: m_pos, spd: m_speed, mov: (m_state != 0), at: m_at};
        sb_q.push_back(e);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        compare_out(tag);
    endtask

    task automatic tick(input string tag, input int cmd);
        exp_t dummy;
        dummy = '{pos: 0, spd: 0, mov: 0, at: 0};
        do_tick(tag, cmd, 1'b0, dummy);
    endtask

    task automatic set_btn(input logic [1:0] b);
        @(negedge clk);
        btn = b;
        repeat (DB_CYC + 4) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tbl_pos[6] = '{241, 242, 244, 246, 249, 252};
        int tbl_spd[6] = '{1, 1, 2, 2, 3, 3};
        int guard;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_pos", int'(bar_pos), RPOS);
        check("rst_speed", int'(speed), 0);
        check("rst_moving", int'(moving), 0);
        check("rst_limit", int'(at_limit), 0);
        reset = 1'b0;

        // ramp down with fixed expectations
        set_btn(2'b10);
        for (int i = 0; i < 6; i++)
            do_tick("ramp", C_DOWN, 1'b1, '{pos: tbl_pos[i], spd: tbl_spd[i], mov: 1, at: 0});
        set_btn(2'b00);
        do_tick("release", C_NONE, 1'b1, '{pos: 252, spd: 0, mov: 0, at: 0});

        // mid-motion async reset, checked before any clock edge
        set_btn(2'b10);
        tick("pre_rst", C_DOWN);
        #2 reset = 1'b1;
        #1;
        check("async_rst_pos", int'(bar_pos), RPOS);
        check("async_rst_speed", int'(speed), 0);
        check("async_rst_moving", int'(moving), 0);
        check("async_rst_limit", int'(at_limit), 0);
        btn = 2'b00;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("tick_in_rst_pos", int'(bar_pos), RPOS);
        repeat (DB_CYC + 4) @(negedge clk);
        reset = 1'b0;
        model_reset();

        // 3-cycle glitch on up is rejected
        @(negedge clk);
        btn = 2'b01;
        repeat (3) @(negedge clk);
        btn = 2'b00;
        repeat (DB_CYC + 4) @(negedge clk);
        tick("glitch", C_NONE);

        // held press: debounced level appears on edge 2+DEBOUNCE_CYCLES
        btn = 2'b01;
        repeat (5) @(negedge clk);
        tick("db_edge6", C_NONE);
        tick("db_edge7", C_UP);
        set_btn(2'b00);
        tick("up_release", C_NONE);

        // drive into lower limit (max_pos)
        set_btn(2'b10);
        guard = 0;
        while (m_pos != 479 && guard < 300) begin
            tick("to_max", C_DOWN);
            guard++;
        end
        check("reach_max", m_pos, 479);
        tick("hold_max0", C_DOWN);
        tick("hold_max1", C_DOWN);

        // shrinking max_pos pulls bar inside on a no-move tick
        btn = 2'b00;
        max_pos = 10'd400;
        repeat (DB_CYC + 4) @(negedge clk);
        tick("shrink", C_NONE);

        // both buttons: no motion
        set_btn(2'b11);
        tick("both0", C_NONE);
        tick("both1", C_NONE);

        // cruise down, then reverse
        set_btn(2'b10);
        for (int i = 0; i < 5; i++) tick("cruise_dn", C_DOWN);
        set_btn(2'b01);
        tick("reverse", C_UP);
        check("reverse_speed_model", m_speed, VMIN);

        // drive up into 0; FSM keeps moving at the limit
        guard = 0;
        while (m_pos != 0 && guard < 300) begin
            tick("to_zero", C_UP);
            guard++;
        end
        check("reach_zero", m_pos, 0);
        tick("hold_zero0", C_UP);
        tick("hold_zero1", C_UP);

        set_btn(2'b00);
        tick("final_idle", C_NONE);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
